mandelbrot_iterator: RTL

//   Per-pixel iteration controller that drives the combinational new_z step (z^2 + c).

---
 rtl/mandelbrot_iterator.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mandelbrot_iterator.sv
// Mandelbrot per-pixel iteration controller: accepts a point c, iterates
// z <= z^2 + c from zero until escape or MAX_ITER, then hands back the count.

module new_z #(
    parameter int W    = 16,
    parameter int FRAC = 12
) (
    input  logic signed [W-1:0] z_real,
    input  logic signed [W-1:0] z_imaginary,
    input  logic signed [W-1:0] c_real,
    input  logic signed [W-1:0] c_imaginary,
    output logic signed [W-1:0] new_real,
    output logic signed [W-1:0] new_imaginary,
    output logic                is_mandelbrot
);
    localparam logic [2*W:0] MAG_LIMIT = (2*W+1)'(4) << (2*FRAC);

    logic signed [2*W-1:0] zr_ext_s;
    logic signed [2*W-1:0] zi_ext_s;
    logic signed [2*W-1:0] re2_s;
    logic signed [2*W-1:0] im2_s;
    logic signed [2*W-1:0] cross_s;
    logic signed [2*W-1:0] diff_s;
    logic signed [2*W-1:0] diff_sh_s;
    logic signed [2*W-1:0] cross_sh_s;
    logic        [2*W:0]   mag_s;
    logic                  sq_ovf_s;

    // Exact squares, then truncate back to Q4.12; 2*zr*zi folds into a shift by FRAC-1.
    always_comb begin
        zr_ext_s   = (2*W)'(z_real);
        zi_ext_s   = (2*W)'(z_imaginary);
        re2_s      = zr_ext_s * zr_ext_s;
        im2_s      = zi_ext_s * zi_ext_s;
        cross_s    = zr_ext_s * zi_ext_s;
        mag_s      = {1'b0, re2_s} + {1'b0, im2_s};
        sq_ovf_s   = (|re2_s[2*W-2:W+FRAC-1]) || (|im2_s[2*W-2:W+FRAC-1]);
        diff_s     = re2_s - im2_s;
        diff_sh_s  = diff_s >>> FRAC;
        cross_sh_s = cross_s >>> (FRAC - 1);
        new_real      = diff_sh_s[W-1:0] + c_real;
        new_imaginary = cross_sh_s[W-1:0] + c_imaginary;
        is_mandelbrot = (mag_s < MAG_LIMIT) && !sq_ovf_s;
    end
endmodule

module mandelbrot_iterator #(
    parameter int FIXED_POINT_WIDTH = 16,
    parameter int MAX_ITER          = 255,
    parameter int ITER_W            = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [FIXED_POINT_WIDTH-1:0] c_real,
    input  logic signed [FIXED_POINT_WIDTH-1:0] c_imaginary,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic        [ITER_W-1:0]            iter_count,
    output logic                                escaped
);
    localparam int FPW = FIXED_POINT_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic signed [FPW-1:0]   z_re_q,      z_re_d;
    logic signed [FPW-1:0]   z_im_q,      z_im_d;
    logic signed [FPW-1:0]   c_re_q,      c_re_d;
    logic signed [FPW-1:0]   c_im_q,      c_im_d;
    logic        [ITER_W-1:0] count_q,    count_d;
    logic                    escaped_q,   escaped_d;
    logic                    in_ready_q,  in_ready_d;
    logic                    out_valid_q, out_valid_d;

    logic signed [FPW-1:0]   nz_re_s;
    logic signed [FPW-1:0]   nz_im_s;
    logic                    bounded_s;

    new_z #(.W(FPW), .FRAC(12)) u_new_z (
        .z_real        (z_re_q),
        .z_imaginary   (z_im_q),
        .c_real        (c_re_q),
        .c_imaginary   (c_im_q),
        .new_real      (nz_re_s),
        .new_imaginary (nz_im_s),
        .is_mandelbrot (bounded_s)
    );

    // Next-state logic; the count register doubles as the reported iteration count.
    always_comb begin
        state_d     = state_q;
        z_re_d      = z_re_q;
        z_im_d      = z_im_q;
        c_re_d      = c_re_q;
        c_im_d      = c_im_q;
        count_d     = count_q;
        escaped_d   = escaped_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    c_re_d     = c_real;
                    c_im_d     = c_imaginary;
                    z_re_d     = {FPW{1'b0}};
                    z_im_d     = {FPW{1'b0}};
                    count_d    = {ITER_W{1'b0}};
                    escaped_d  = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = ITER;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ITER: begin
                if (!bounded_s) begin
                    escaped_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (count_q == ITER_W'(MAX_ITER - 1)) begin
                    count_d     = ITER_W'(MAX_ITER);
                    escaped_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    z_re_d  = nz_re_s;
                    z_im_d  = nz_im_s;
                    count_d = count_q + ITER_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any point in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            z_re_q      <= {FPW{1'b0}};
            z_im_q      <= {FPW{1'b0}};
            c_re_q      <= {FPW{1'b0}};
            c_im_q      <= {FPW{1'b0}};
            count_q     <= {ITER_W{1'b0}};
            escaped_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            z_re_q      <= z_re_d;
            z_im_q      <= z_im_d;
            c_re_q      <= c_re_d;
            c_im_q      <= c_im_d;
            count_q     <= count_d;
            escaped_q   <= escaped_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign iter_count = count_q;
    assign escaped    = escaped_q;
endmodule
